// File: rtl/mouse_pkg.sv
// ---------------------------------------------------------------------------
// mouse_pkg
// Shared definitions for the PS/2 mouse host logic (transmitter and receiver):
// transmitter state encoding, common mouse command bytes, default cycle
// counts at a 50 MHz system clock and the PS/2 parity helper.
// ---------------------------------------------------------------------------
package mouse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CLK_LOW      = 3'd1,
    ST_START        = 3'd2,
    ST_DATA         = 3'd3,
    ST_STOP         = 3'd4,
    ST_ACK_WAIT     = 3'd5,
    ST_RELEASE_WAIT = 3'd6
  } mouse_state_e;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  // 120 us clock hold and 2 ms event timeout at 50 MHz.
  localparam int DEF_CLK_HOLD_CYCLES = 6000;
  localparam int DEF_TIMEOUT_CYCLES  = 100000;

  // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_edge_detect.sv
// ---------------------------------------------------------------------------
// ps2_edge_detect
// Registers the (already synchronised) PS/2 clock once and flags its falling
// edge. Shared by the mouse transmitter and receiver.
//   CLK        in  system clock
//   RESET      in  synchronous, active-high reset
//   i_ps2_clk  in  sampled PS/2 clock line
//   o_fall     out one-cycle strobe: line was high last cycle, low now
// ---------------------------------------------------------------------------
module ps2_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic i_ps2_clk,
  output logic o_fall
);

  logic r_clk_dly;

  // Reset to the idle (released, pulled-up) line level.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) r_clk_dly <= 1'b1;
    else       r_clk_dly <= i_ps2_clk;
  end

  assign o_fall = r_clk_dly & ~i_ps2_clk;

endmodule

// File: rtl/mouse_transmitter.sv
// ---------------------------------------------------------------------------
// mouse_transmitter
// Host-to-device PS/2 transmitter: sends one command byte to the mouse by
// holding the mouse clock low (request to send), presenting a start bit and
// then shifting data LSB first, odd parity and stop on the mouse's falling
// clock edges, and finally checking the mouse ACK. Only line-drive enables
// are produced; the tristate buffers live in the wrapper.
//   CLK, RESET         system clock, synchronous active-high reset
//   CLK_MOUSE_IN       sampled mouse clock line
//   DATA_MOUSE_IN      sampled mouse data line
//   CLK_MOUSE_OUT_EN   1 = pull mouse clock low
//   DATA_MOUSE_OUT     value on data while DATA_MOUSE_OUT_EN = 1
//   DATA_MOUSE_OUT_EN  1 = drive data line
//   SEND_BYTE          one-cycle request, accepted only when idle
//   BYTE_TO_SEND       command byte, latched on accept
//   BYTE_SENT          one-cycle pulse: ACK seen and lines released
//   BYTE_ERROR         one-cycle pulse: missing ACK or timeout
//   BUSY               high whenever not idle
// ---------------------------------------------------------------------------
module mouse_transmitter
  import mouse_pkg::*;
#(
  parameter int CLK_HOLD_CYCLES = DEF_CLK_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BYTE_SENT,
  output logic       BYTE_ERROR,
  output logic       BUSY
);

  // One counter serves both the clock hold and the event timeout; they never
  // run in the same state.
  localparam int MAX_CYCLES = (CLK_HOLD_CYCLES > TIMEOUT_CYCLES) ? CLK_HOLD_CYCLES
                                                                 : TIMEOUT_CYCLES;
  localparam int TW = $clog2(MAX_CYCLES + 1);

  mouse_state_e r_state;
  mouse_state_e w_state_next;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_byte;
  logic          r_data_out;
  logic          r_byte_sent;
  logic          r_byte_error;

  logic w_fall;
  logic w_hold_done;
  logic w_timeout;
  logic w_done;
  logic w_error;
  logic w_clk_out_en;
  logic w_data_out_en;
  logic w_busy;

  ps2_edge_detect u_edge (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_ps2_clk (CLK_MOUSE_IN),
    .o_fall    (w_fall)
  );

  assign w_hold_done = (r_timer == TW'(CLK_HOLD_CYCLES - 1));
  assign w_timeout   = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next  = r_state;
    w_done        = 1'b0;
    w_error       = 1'b0;
    w_clk_out_en  = 1'b0;
    w_data_out_en = 1'b0;
    w_busy        = 1'b1;

    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (SEND_BYTE) w_state_next = ST_CLK_LOW;
      end

      ST_CLK_LOW: begin
        w_clk_out_en = 1'b1;
        if (w_hold_done) w_state_next = ST_START;
      end

      ST_START: begin
        w_data_out_en = 1'b1;
        if (w_fall) begin
          w_state_next = ST_DATA;
        end else if (w_timeout) begin
          w_error      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end

      ST_DATA: begin
        w_data_out_en = 1'b1;
        if (w_fall) begin
          if (r_bit_cnt == 4'd8) w_state_next = ST_STOP;
        end else if (w_timeout) begin
          w_error      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end

      ST_STOP: begin
        w_data_out_en = 1'b1;
        if (w_fall) begin
          w_state_next = ST_ACK_WAIT;
        end else if (w_timeout) begin
          w_error      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end

      ST_ACK_WAIT: begin
        if (w_fall) begin
          if (DATA_MOUSE_IN) begin
            w_error      = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_RELEASE_WAIT;
          end
        end else if (w_timeout) begin
          w_error      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end

      ST_RELEASE_WAIT: begin
        if (CLK_MOUSE_IN && DATA_MOUSE_IN) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_timeout) begin
          w_error      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_busy       = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_bit_cnt    <= '0;
      r_byte       <= '0;
      r_data_out   <= 1'b0;
      r_byte_sent  <= 1'b0;
      r_byte_error <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_byte_sent  <= w_done;
      r_byte_error <= w_error;

      // Our own clock pull-down shows up as a falling edge during the hold,
      // so edges only restart the timer once the clock has been released.
      if (r_state == ST_IDLE || w_state_next != r_state ||
          (w_fall && r_state != ST_CLK_LOW))
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (SEND_BYTE) begin
            r_byte     <= BYTE_TO_SEND;
            r_bit_cnt  <= '0;
            r_data_out <= 1'b0;
          end
        end
        ST_START: begin
          if (w_fall) begin
            r_data_out <= r_byte[0];
            r_bit_cnt  <= 4'd1;
          end
        end
        ST_DATA: begin
          if (w_fall) begin
            if (r_bit_cnt < 4'd8) begin
              r_data_out <= r_byte[r_bit_cnt[2:0]];
              r_bit_cnt  <= r_bit_cnt + 4'd1;
            end else begin
              r_data_out <= odd_parity(r_byte);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The start bit is the cleared r_data_out; gating with the enable keeps the
  // data output at 0 whenever the line is released.
  assign CLK_MOUSE_OUT_EN  = w_clk_out_en;
  assign DATA_MOUSE_OUT_EN = w_data_out_en;
  assign DATA_MOUSE_OUT    = w_data_out_en & r_data_out;
  assign BYTE_SENT         = r_byte_sent;
  assign BYTE_ERROR        = r_byte_error;
  assign BUSY              = w_busy;

endmodule

// File: tb/tb_mouse_transmitter.sv
module tb_mouse_transmitter;
  import mouse_pkg::*;

  localparam int HOLD = 600;
  localparam int TMO  = 3000;

  typedef enum int {M_NORMAL, M_NOACK, M_INJECT, M_RESET, M_TIMEOUT} mode_e;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN;
  logic       BYTE_SENT, BYTE_ERROR, BUSY;
  logic       bfm_clk, bfm_data;
  logic       clk_line, data_line;

  // Open-collector bus: any driver pulling low wins, otherwise pulled up.
  assign clk_line  = bfm_clk & ~CLK_MOUSE_OUT_EN;
  assign data_line = bfm_data & ~(DATA_MOUSE_OUT_EN & ~DATA_MOUSE_OUT);

  mouse_transmitter #(
    .CLK_HOLD_CYCLES (HOLD),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .CLK_MOUSE_IN      (clk_line),
    .DATA_MOUSE_IN     (data_line),
    .CLK_MOUSE_OUT_EN  (CLK_MOUSE_OUT_EN),
    .DATA_MOUSE_OUT    (DATA_MOUSE_OUT),
    .DATA_MOUSE_OUT_EN (DATA_MOUSE_OUT_EN),
    .SEND_BYTE         (SEND_BYTE),
    .BYTE_TO_SEND      (BYTE_TO_SEND),
    .BYTE_SENT         (BYTE_SENT),
    .BYTE_ERROR        (BYTE_ERROR),
    .BUSY              (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0;
  int sent_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0, ovl_cnt = 0;
  int exp_sent = 0, exp_err = 0;
  logic prev_sent = 1'b0, prev_err = 1'b0;

  // Pulse and line-enable observer.
  always @(negedge CLK) begin
    if (BYTE_SENT) sent_cnt++;
    if (BYTE_ERROR) err_cnt++;
    if (BYTE_SENT && BYTE_ERROR) both_cnt++;
    if ((BYTE_SENT && prev_sent) || (BYTE_ERROR && prev_err)) long_cnt++;
    if (CLK_MOUSE_OUT_EN && DATA_MOUSE_OUT_EN) ovl_cnt++;
    prev_sent = BYTE_SENT;
    prev_err  = BYTE_ERROR;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Frame as seen by the mouse: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic run_frame(input logic [7:0] b, input mode_e mode, input int half);
    logic [10:0] got, exp;
    int n, base_s, base_e;
    exp    = model_frame(b);
    got    = '0;
    base_s = sent_cnt;
    base_e = err_cnt;

    @(negedge CLK);
    SEND_BYTE = 1'b1;
    BYTE_TO_SEND = b;
    @(negedge CLK);
    SEND_BYTE = 1'b0;
    BYTE_TO_SEND = 8'($urandom);

    n = 0;
    while (CLK_MOUSE_OUT_EN && n < HOLD + 100) begin
      n++;
      @(negedge CLK);
    end
    check("clk_hold_len", n, HOLD);

    if (mode == M_TIMEOUT) begin
      n = 0;
      while (!BYTE_ERROR && n < TMO + 100) begin
        @(negedge CLK);
        n++;
      end
      check("timeout_len", n, TMO);
      check("timeout_clk_en", CLK_MOUSE_OUT_EN, 0);
      check("timeout_data_en", DATA_MOUSE_OUT_EN, 0);
      check("timeout_busy", BUSY, 0);
      exp_err++;
      wait_cyc(3);
      return;
    end

    wait_cyc(10);
    got[0] = data_line;
    for (int i = 1; i <= 11; i++) begin
      bfm_clk = 1'b0;
      wait_cyc(half);
      if (mode == M_RESET && i == 4) begin
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_clk_en", CLK_MOUSE_OUT_EN, 0);
        check("rst_data_en", DATA_MOUSE_OUT_EN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_pulses", {BYTE_SENT, BYTE_ERROR}, 0);
        RESET = 1'b0;
        bfm_clk = 1'b1;
        bfm_data = 1'b1;
        wait_cyc(5);
        return;
      end
      if (i <= 10) got[i] = data_line;
      bfm_clk = 1'b1;
      if (mode == M_INJECT && i == 5) begin
        SEND_BYTE = 1'b1;
        BYTE_TO_SEND = 8'h55;
        @(negedge CLK);
        SEND_BYTE = 1'b0;
        wait_cyc(half - 1);
      end else if (i == 10) begin
        wait_cyc(half / 2);
        bfm_data = (mode == M_NOACK);
        wait_cyc(half - half / 2);
      end else begin
        wait_cyc(half);
      end
    end
    bfm_data = 1'b1;

    n = 0;
    while (sent_cnt == base_s && err_cnt == base_e && n < 500) begin
      @(negedge CLK);
      n++;
    end
    wait_cyc(2);
    check("frame_bits", got, exp);
    if (mode == M_NOACK) begin
      exp_err++;
      check("noack_err_pulses", err_cnt - base_e, 1);
      check("noack_sent_pulses", sent_cnt - base_s, 0);
    end else begin
      exp_sent++;
      check("sent_pulses", sent_cnt - base_s, 1);
      check("err_pulses", err_cnt - base_e, 0);
    end
    check("end_busy", BUSY, 0);
    check("end_enables", {CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}, 0);
  endtask

  initial begin
    RESET = 1'b1;
    SEND_BYTE = 1'b0;
    BYTE_TO_SEND = 8'h00;
    bfm_clk = 1'b1;
    bfm_data = 1'b1;
    wait_cyc(3);
    check("reset_clk_en", CLK_MOUSE_OUT_EN, 0);
    check("reset_data_en", DATA_MOUSE_OUT_EN, 0);
    check("reset_data_out", DATA_MOUSE_OUT, 0);
    check("reset_pulses", {BYTE_SENT, BYTE_ERROR}, 0);
    check("reset_busy", BUSY, 0);
    RESET = 1'b0;
    wait_cyc(2);

    run_frame(CMD_RESET, M_NORMAL, 40);
    run_frame(CMD_ENABLE, M_NORMAL, 35);
    run_frame(8'($urandom), M_NOACK, 30);
    run_frame(8'($urandom), M_TIMEOUT, 30);
    run_frame(8'hAA, M_INJECT, 40);
    run_frame(8'($urandom), M_RESET, 40);
    run_frame(8'($urandom), M_NORMAL, 32);
    for (int k = 0; k < 4; k++)
      run_frame(8'($urandom), M_NORMAL, int'($urandom_range(50, 25)));

    wait_cyc(5);
    check("total_sent", sent_cnt, exp_sent);
    check("total_err", err_cnt, exp_err);
    check("pulse_overlap", both_cnt, 0);
    check("pulse_width", long_cnt, 0);
    check("enable_overlap", ovl_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mouse_transmitter.md
Name: mouse_transmitter

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xFF reset, 0xF4 enable streaming) to the mouse over the shared open-collector CLK/DATA lines.
- Sits beside the mouse receiver under the mouse master FSM. The master pulses SEND_BYTE and waits for BYTE_SENT or BYTE_ERROR.
- Owns only the line-drive enables. Tristate buffers live in the top-level wrapper.

Parameters:
- CLK_HOLD_CYCLES, 6000: CLK cycles the mouse clock is held low to request to send (120 us at 50 MHz, at least 100 us required).
- TIMEOUT_CYCLES, 100000: maximum CLK cycles waited for any expected mouse clock/data event (2 ms at 50 MHz).

Ports:
- CLK  in  1  system clock, 50 MHz
- RESET  in  1  synchronous, active-high reset
- CLK_MOUSE_IN  in  1  sampled mouse clock line
- DATA_MOUSE_IN  in  1  sampled mouse data line
- CLK_MOUSE_OUT_EN  out  1  1 = pull mouse clock low
- DATA_MOUSE_OUT  out  1  value driven on data when DATA_MOUSE_OUT_EN=1
- DATA_MOUSE_OUT_EN  out  1  1 = drive data line
- SEND_BYTE  in  1  one-cycle request; accepted only in IDLE
- BYTE_TO_SEND  in  8  command byte, latched on accept
- BYTE_SENT  out  1  one-cycle pulse on successful completion (ACK seen, lines released)
- BYTE_ERROR  out  1  one-cycle pulse on missing ACK or timeout
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Falling edge is defined as ClkDly & ~CLK_MOUSE_IN, where ClkDly is CLK_MOUSE_IN registered once.
- Reset values: all outputs 0, state IDLE, bit counter 0, timeout counter 0, latched byte 0x00. Reset mid-transfer releases both lines on the next CLK edge.
- IDLE
  - Lines released.
  - SEND_BYTE=1: latch BYTE_TO_SEND, clear counters, go to CLK_LOW.
- CLK_LOW
  - CLK_MOUSE_OUT_EN=1.
  - After CLK_HOLD_CYCLES cycles in the state, go to START.
- START
  - CLK_MOUSE_OUT_EN=0; DATA_MOUSE_OUT_EN=1, DATA_MOUSE_OUT=0 (start bit).
  - On the first falling edge, drive bit0 and go to DATA with bitcount=1.
- DATA
  - On each falling edge: if bitcount<8, drive byte[bitcount] and increment bitcount.
  - If bitcount==8, drive parity = ~^byte (odd parity) and go to STOP.
  - Bits go out LSB first; the mouse samples on rising edges.
- STOP
  - On a falling edge, release data (DATA_MOUSE_OUT_EN=0) and go to ACK_WAIT.
- ACK_WAIT
  - On a falling edge with DATA_MOUSE_IN=0, go to RELEASE_WAIT.
  - On a falling edge with DATA_MOUSE_IN=1, pulse BYTE_ERROR and go to IDLE.
- RELEASE_WAIT
  - When CLK_MOUSE_IN=1 and DATA_MOUSE_IN=1 in the same cycle, pulse BYTE_SENT next cycle and go to IDLE.
- Timeout
  - Timeout counter resets on every falling edge and on each state entry.
  - In START, DATA, STOP, ACK_WAIT and RELEASE_WAIT, reaching TIMEOUT_CYCLES pulses BYTE_ERROR, releases lines and returns to IDLE.
- Pulses are exclusive: BYTE_SENT and BYTE_ERROR are never high together, and each is high for exactly one cycle.
- SEND_BYTE while BUSY is ignored; no queueing.
- Unused state encodings return to IDLE with all outputs cleared.
- CLK_MOUSE_OUT_EN and DATA_MOUSE_OUT_EN are never both 1 except transiently at the CLK_LOW-to-START boundary, which is allowed to be 0 cycles.

Decomposition:
- Shared package mouse_pkg:
  - state encoding constants (IDLE..RELEASE_WAIT)
  - command constants CMD_RESET=0xFF, CMD_ENABLE=0xF4
  - default cycle counts
- The receiver reuses the package.
- One natural sub-module, ps2_edge_detect: registers the clock and outputs a falling-edge strobe. It is shared with the receiver.

Test Plan:
- SEND_BYTE with 0xFF and a mouse BFM clocking at ~12 kHz -> CLK_MOUSE_OUT_EN high for exactly 6000 cycles, then bits 0,1,1,1,1,1,1,1,1,1 (start, data LSB first, parity=1) sampled at BFM rising edges; BFM ACK -> BYTE_SENT single pulse, BUSY falls.
- Send 0xF4 -> data bits 0,0,1,0,1,1,1,1 and parity 0; BFM ACK -> BYTE_SENT.
- BFM leaves data high at the ACK clock -> BYTE_ERROR pulse, no BYTE_SENT, lines released.
- BFM never clocks after the clock hold -> BYTE_ERROR exactly 100000 cycles after START entry; both enables 0.
- SEND_BYTE with 0x55 re-asserted mid-transfer of 0xAA -> the transmitted byte stays 0xAA.
- RESET asserted during DATA -> next cycle all enables 0, BUSY 0, no pulses; a subsequent send works normally.
